// File: rtl/multi_issue_rs.sv
// Unified reservation station: DISPATCH_W-wide dispatch, CDB wakeup and
// oldest-first ISSUE_W-wide select from one shared age-ordered pool.
module multi_issue_rs #(
    parameter int DISPATCH_W = 2,
    parameter int ISSUE_W    = 2,
    parameter int CDB_W      = 2,
    parameter int DEPTH      = 8,
    parameter int PRF_IDX    = 6,
    parameter int ROB_IDX    = 5,
    parameter int PAYLOAD_W  = 104
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [DISPATCH_W-1:0]            disp_valid,
    input  logic [DISPATCH_W*PRF_IDX-1:0]    disp_prega,
    input  logic [DISPATCH_W-1:0]            disp_prega_rdy,
    input  logic [DISPATCH_W*PRF_IDX-1:0]    disp_pregb,
    input  logic [DISPATCH_W-1:0]            disp_pregb_rdy,
    input  logic [DISPATCH_W*PRF_IDX-1:0]    disp_pdest,
    input  logic [DISPATCH_W*ROB_IDX-1:0]    disp_rob,
    input  logic [DISPATCH_W*PAYLOAD_W-1:0]  disp_payload,
    output logic                             rs_stall,
    input  logic [CDB_W-1:0]                 cdb_valid,
    input  logic [CDB_W*PRF_IDX-1:0]         cdb_tag,
    input  logic [ISSUE_W-1:0]               fu_free,
    input  logic                             flush_all,
    input  logic [DEPTH-1:0]                 entry_flush,
    output logic [ISSUE_W-1:0]               iss_valid,
    output logic [ISSUE_W*PRF_IDX-1:0]       iss_prega,
    output logic [ISSUE_W*PRF_IDX-1:0]       iss_pregb,
    output logic [ISSUE_W*PRF_IDX-1:0]       iss_pdest,
    output logic [ISSUE_W*ROB_IDX-1:0]       iss_rob,
    output logic [ISSUE_W*PAYLOAD_W-1:0]     iss_payload,
    output logic [ISSUE_W*$clog2(DEPTH)-1:0] iss_rs_idx,
    output logic [$clog2(DEPTH):0]           free_count
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    function automatic logic cdb_hit(
        input logic [PRF_IDX-1:0]       tag,
        input logic [CDB_W-1:0]         vld,
        input logic [CDB_W*PRF_IDX-1:0] tags
    );
        logic hit;
        hit = 1'b0;
        for (int c = 0; c < CDB_W; c++) begin
            if (vld[c] && tags[c*PRF_IDX +: PRF_IDX] == tag) hit = 1'b1;
        end
        return hit;
    endfunction

    logic [DEPTH-1:0]     valid_q, valid_d;
    logic [DEPTH-1:0]     rdya_q, rdya_d;
    logic [DEPTH-1:0]     rdyb_q, rdyb_d;
    // older_q[i][j] set means entry i was dispatched before entry j
    logic [DEPTH-1:0]     older_q [DEPTH];
    logic [DEPTH-1:0]     older_d [DEPTH];
    logic [CNT_W-1:0]     free_q, free_d;
    logic [PRF_IDX-1:0]   prega_q [DEPTH];
    logic [PRF_IDX-1:0]   pregb_q [DEPTH];
    logic [PRF_IDX-1:0]   pdest_q [DEPTH];
    logic [ROB_IDX-1:0]   rob_q [DEPTH];
    logic [PAYLOAD_W-1:0] payload_q [DEPTH];

    logic [ISSUE_W-1:0]           iss_valid_q, iss_valid_d;
    logic [ISSUE_W*PRF_IDX-1:0]   iss_prega_q, iss_prega_d;
    logic [ISSUE_W*PRF_IDX-1:0]   iss_pregb_q, iss_pregb_d;
    logic [ISSUE_W*PRF_IDX-1:0]   iss_pdest_q, iss_pdest_d;
    logic [ISSUE_W*ROB_IDX-1:0]   iss_rob_q, iss_rob_d;
    logic [ISSUE_W*PAYLOAD_W-1:0] iss_payload_q, iss_payload_d;
    logic [ISSUE_W*IDX_W-1:0]     iss_idx_q, iss_idx_d;

    logic [DEPTH-1:0]      elig, taken, cand, used;
    logic [ISSUE_W-1:0]    sel_v;
    logic [IDX_W-1:0]      sel_idx [ISSUE_W];
    logic                  blocked;
    logic [DISPATCH_W-1:0] lane_we;
    logic [IDX_W-1:0]      lane_idx [DISPATCH_W];
    logic                  disp_ok;

    assign rs_stall = free_q < CNT_W'(DISPATCH_W);
    assign disp_ok  = !rs_stall && !flush_all;

    // Oldest-first select: an entry wins unless an older candidate remains
    always_comb begin
        elig = valid_q & rdya_q & rdyb_q & ~entry_flush;
        if (flush_all) elig = '0;
        taken   = '0;
        cand    = '0;
        blocked = 1'b0;
        for (int k = 0; k < ISSUE_W; k++) begin
            sel_v[k]   = 1'b0;
            sel_idx[k] = '0;
            cand       = elig & ~taken;
            if (fu_free[k]) begin
                for (int i = 0; i < DEPTH; i++) begin
                    blocked = 1'b0;
                    for (int j = 0; j < DEPTH; j++) begin
                        if (j != i && cand[j] && older_q[j][i]) blocked = 1'b1;
                    end
                    if (cand[i] && !blocked && !sel_v[k]) begin
                        sel_v[k]   = 1'b1;
                        sel_idx[k] = IDX_W'(i);
                    end
                end
                if (sel_v[k]) taken[sel_idx[k]] = 1'b1;
            end
        end
    end

    always_comb begin
        used = '0;
        for (int l = 0; l < DISPATCH_W; l++) begin
            lane_we[l]  = 1'b0;
            lane_idx[l] = '0;
            if (disp_ok && disp_valid[l]) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (!lane_we[l] && !valid_q[i] && !used[i]) begin
                        lane_we[l]  = 1'b1;
                        lane_idx[l] = IDX_W'(i);
                    end
                end
            end
            if (lane_we[l]) used[lane_idx[l]] = 1'b1;
        end
    end

    always_comb begin
        valid_d = valid_q;
        rdya_d  = rdya_q;
        rdyb_d  = rdyb_q;
        older_d = older_q;
        for (int i = 0; i < DEPTH; i++) begin
            rdya_d[i] = rdya_q[i] | cdb_hit(prega_q[i], cdb_valid, cdb_tag);
            rdyb_d[i] = rdyb_q[i] | cdb_hit(pregb_q[i], cdb_valid, cdb_tag);
        end
        for (int k = 0; k < ISSUE_W; k++) begin
            if (sel_v[k]) valid_d[sel_idx[k]] = 1'b0;
        end
        valid_d = valid_d & ~entry_flush;
        if (flush_all) valid_d = '0;
        // Later lanes see earlier lanes' column bits, so lane order sets age
        for (int l = 0; l < DISPATCH_W; l++) begin
            if (lane_we[l]) begin
                valid_d[lane_idx[l]] = 1'b1;
                rdya_d[lane_idx[l]] = disp_prega_rdy[l] | cdb_hit(
                    disp_prega[l*PRF_IDX +: PRF_IDX], cdb_valid, cdb_tag);
                rdyb_d[lane_idx[l]] = disp_pregb_rdy[l] | cdb_hit(
                    disp_pregb[l*PRF_IDX +: PRF_IDX], cdb_valid, cdb_tag);
                for (int j = 0; j < DEPTH; j++) older_d[j][lane_idx[l]] = 1'b1;
                older_d[lane_idx[l]] = '0;
            end
        end
        free_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!valid_d[i]) free_d = free_d + CNT_W'(1);
        end
    end

    always_comb begin
        iss_valid_d   = sel_v;
        iss_prega_d   = '0;
        iss_pregb_d   = '0;
        iss_pdest_d   = '0;
        iss_rob_d     = '0;
        iss_payload_d = '0;
        iss_idx_d     = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            if (sel_v[k]) begin
                iss_prega_d[k*PRF_IDX +: PRF_IDX]     = prega_q[sel_idx[k]];
                iss_pregb_d[k*PRF_IDX +: PRF_IDX]     = pregb_q[sel_idx[k]];
                iss_pdest_d[k*PRF_IDX +: PRF_IDX]     = pdest_q[sel_idx[k]];
                iss_rob_d[k*ROB_IDX +: ROB_IDX]       = rob_q[sel_idx[k]];
                iss_payload_d[k*PAYLOAD_W +: PAYLOAD_W] = payload_q[sel_idx[k]];
                iss_idx_d[k*IDX_W +: IDX_W]           = sel_idx[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q       <= '0;
            rdya_q        <= '0;
            rdyb_q        <= '0;
            for (int i = 0; i < DEPTH; i++) older_q[i] <= '0;
            free_q        <= CNT_W'(DEPTH);
            iss_valid_q   <= '0;
            iss_prega_q   <= '0;
            iss_pregb_q   <= '0;
            iss_pdest_q   <= '0;
            iss_rob_q     <= '0;
            iss_payload_q <= '0;
            iss_idx_q     <= '0;
        end else begin
            valid_q       <= valid_d;
            rdya_q        <= rdya_d;
            rdyb_q        <= rdyb_d;
            older_q       <= older_d;
            free_q        <= free_d;
            iss_valid_q   <= iss_valid_d;
            iss_prega_q   <= iss_prega_d;
            iss_pregb_q   <= iss_pregb_d;
            iss_pdest_q   <= iss_pdest_d;
            iss_rob_q     <= iss_rob_d;
            iss_payload_q <= iss_payload_d;
            iss_idx_q     <= iss_idx_d;
        end
    end

    // Operand fields are only meaningful while the entry is valid
    always_ff @(posedge clk) begin
        for (int l = 0; l < DISPATCH_W; l++) begin
            if (lane_we[l]) begin
                prega_q[lane_idx[l]]   <= disp_prega[l*PRF_IDX +: PRF_IDX];
                pregb_q[lane_idx[l]]   <= disp_pregb[l*PRF_IDX +: PRF_IDX];
                pdest_q[lane_idx[l]]   <= disp_pdest[l*PRF_IDX +: PRF_IDX];
                rob_q[lane_idx[l]]     <= disp_rob[l*ROB_IDX +: ROB_IDX];
                payload_q[lane_idx[l]] <= disp_payload[l*PAYLOAD_W +: PAYLOAD_W];
            end
        end
    end

    assign iss_valid   = iss_valid_q;
    assign iss_prega   = iss_prega_q;
    assign iss_pregb   = iss_pregb_q;
    assign iss_pdest   = iss_pdest_q;
    assign iss_rob     = iss_rob_q;
    assign iss_payload = iss_payload_q;
    assign iss_rs_idx  = iss_idx_q;
    assign free_count  = free_q;

endmodule
